// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC unit: default widths, the sequential
// PC step and the fetch FSM state encoding.
package pc_pkg;

  localparam int ADDR_W_DEF  = 64;
  localparam int INST_W_DEF  = 32;
  localparam int PC_STEP_DEF = 4;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // A resolved control-flow report only redirects when it was taken.
  function automatic logic is_redirect(input logic valid, input logic taken);
    return valid & taken;
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Redirect target: register target for BR, otherwise branch PC plus the
// word-scaled sign-extended immediate. Wraps modulo 2^ADDR_W.
module branch_target_calc import pc_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              br_reg_i,
  input  logic [ADDR_W-1:0] br_pc_i,
  input  logic [63:0]       ext_imm_i,
  input  logic [ADDR_W-1:0] reg_target_i,
  output logic [ADDR_W-1:0] target_o
);

  logic [63:0] offset;

  // Immediates count instructions; scale to bytes (low two bits become zero).
  assign offset   = ext_imm_i << 2;
  assign target_o = br_reg_i ? reg_target_i : br_pc_i + offset[ADDR_W-1:0];

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: owns the PC, fetches over a req/ack memory handshake and
// holds one instruction for decode. Taken branches redirect the PC; a fetch
// in flight during a redirect is completed and its data dropped.
// Optional FETCH_PERF_CNT_EN adds fetch_count / flush_count outputs.
module fetch_pc_unit import pc_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INST_W  = INST_W_DEF,
  parameter int PC_STEP = PC_STEP_DEF
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic [ADDR_W-1:0] StartPC,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              br_valid,
  input  logic              br_taken,
  input  logic              br_reg,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [63:0]       ExtImm,
  input  logic [ADDR_W-1:0] RegTarget
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       flush_count
`endif
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;
  logic [ADDR_W-1:0] target;
  logic              redirect;

  branch_target_calc #(.ADDR_W(ADDR_W)) u_tgt (
    .br_reg_i     (br_reg),
    .br_pc_i      (br_pc),
    .ext_imm_i    (ExtImm),
    .reg_target_i (RegTarget),
    .target_o     (target)
  );

  // Redirects arriving before the PC is loaded from StartPC are ignored.
  assign redirect = (state_q != ST_BOOT) && is_redirect(br_valid, br_taken);

  assign imem_req   = (state_q == ST_FETCH);
  // While a killed request is outstanding the address must stay on the old PC.
  assign imem_addr  = drop_q ? drop_addr_q : pc_q;
  assign inst_valid = (state_q == ST_HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

  // Next-state logic for the fetch FSM, PC and held instruction.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    drop_d      = drop_q;
    drop_addr_d = drop_addr_q;
    case (state_q)
      ST_BOOT: begin
        pc_d    = StartPC;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect) begin
          pc_d = target;
          if (imem_ack) begin
            drop_d = 1'b0;
          end else begin
            drop_d = 1'b1;
            if (!drop_q) drop_addr_d = pc_q;
          end
        end else if (imem_ack) begin
          if (drop_q) begin
            drop_d = 1'b0;
          end else begin
            inst_d    = imem_data;
            inst_pc_d = pc_q;
            pc_d      = pc_q + ADDR_W'(PC_STEP);
            state_d   = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = ST_FETCH;
        end else if (inst_ready) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q     <= ST_BOOT;
      pc_q        <= '0;
      inst_q      <= '0;
      inst_pc_q   <= '0;
      drop_q      <= 1'b0;
      drop_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      drop_q      <= drop_d;
      drop_addr_q <= drop_addr_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;

  // Accepted-instruction and redirect counters, free-running and wrapping.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (inst_valid && inst_ready && !redirect) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: stimulus pushes expected fetch
// addresses and delivered instructions; a negedge monitor pops and compares.
module tb_fetch_pc_unit;

  logic        CLK = 1'b0;
  logic        resetl;
  logic [63:0] StartPC;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;
  logic        br_valid, br_taken, br_reg;
  logic [63:0] br_pc, ExtImm, RegTarget;

  typedef struct {
    logic [31:0] d;
    logic [63:0] pc;
  } inst_t;

  logic [63:0] exp_addr[$];
  inst_t       exp_inst[$];
  inst_t       mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  int          wait_cycles = 0;
  int          cnt = 0;
  logic        fixed_mode = 1'b1;

  always #5 CLK = ~CLK;

  fetch_pc_unit dut (
    .CLK(CLK), .resetl(resetl), .StartPC(StartPC),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .br_valid(br_valid), .br_taken(br_taken), .br_reg(br_reg), .br_pc(br_pc),
    .ExtImm(ExtImm), .RegTarget(RegTarget)
  );

  function automatic logic [31:0] dgen(input logic [63:0] a);
    return 32'hA500_0000 | {8'h00, a[23:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!inst_valid && n < 50) begin tick(); n++; end
    check(name, {63'd0, inst_valid}, 64'd1);
  endtask

  task automatic wait_inst_drain(input string name);
    int n = 0;
    while (exp_inst.size() != 0 && n < 100) begin tick(); n++; end
    check(name, 64'(exp_inst.size()), 64'd0);
  endtask

  task automatic push_inst(input logic [31:0] d, input logic [63:0] pc);
    inst_t e;
    e.d = d; e.pc = pc;
    exp_inst.push_back(e);
  endtask

  // Instruction memory: acks after wait_cycles idle request cycles.
  initial begin
    imem_ack = 1'b0; imem_data = '0;
    forever begin
      @(posedge CLK); #1;
      if (!resetl || imem_ack) begin
        imem_ack = 1'b0; cnt = 0;
      end else if (imem_req) begin
        if (cnt >= wait_cycles) begin
          imem_ack  = 1'b1;
          imem_data = fixed_mode ? 32'h8B02_0020 : dgen(imem_addr);
        end else cnt++;
      end else cnt = 0;
    end
  end

  // Monitor: compares every completed fetch and every accepted instruction.
  always @(negedge CLK) begin
    if (resetl) begin
      if (imem_req && imem_ack) begin
        if (exp_addr.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_fetch: got addr 0x%0h expected none", imem_addr);
        end else check("fetch_addr", imem_addr, exp_addr.pop_front());
      end
      if (inst_valid && inst_ready && !(br_valid && br_taken)) begin
        if (exp_inst.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_inst: got pc 0x%0h expected none", inst_pc);
        end else begin
          mon_e = exp_inst.pop_front();
          check("deliver_inst", {32'd0, inst}, {32'd0, mon_e.d});
          check("deliver_pc", inst_pc, mon_e.pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetl = 1'b1; StartPC = 64'h1000; inst_ready = 1'b1;
    br_valid = 0; br_taken = 0; br_reg = 0; br_pc = '0; ExtImm = '0; RegTarget = '0;
    #1 resetl = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_req",   {63'd0, imem_req},   64'd0);
    check("rst_addr",  imem_addr,           64'd0);
    check("rst_valid", {63'd0, inst_valid}, 64'd0);
    check("rst_inst",  {32'd0, inst},       64'd0);
    check("rst_pc",    inst_pc,             64'd0);

    // Boot stream, zero-wait memory, decode always ready.
    exp_addr.push_back(64'h1000); exp_addr.push_back(64'h1004);
    exp_addr.push_back(64'h1008); exp_addr.push_back(64'h100C);
    push_inst(32'h8B02_0020, 64'h1000);
    push_inst(32'h8B02_0020, 64'h1004);
    push_inst(32'h8B02_0020, 64'h1008);
    resetl = 1'b1;
    wait_inst_drain("boot_stream");
    inst_ready = 1'b0;

    // Back-pressure: held instruction stable, no requests.
    wait_valid("bp_valid_rise");
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {63'd0, inst_valid}, 64'd1);
      check("bp_req",   {63'd0, imem_req},   64'd0);
      check("bp_pc",    inst_pc,             64'h100C);
      check("bp_inst",  {32'd0, inst},       64'h8B02_0020);
      tick();
    end
    exp_addr.push_back(64'h1010);
    push_inst(32'h8B02_0020, 64'h100C);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    wait_valid("bp_next_valid");
    check("bp_next_pc", inst_pc, 64'h1010);
    fixed_mode = 1'b0;

    // PC-relative taken branch, decode ready in the same cycle (killed).
    exp_addr.push_back(64'h0EDC);
    br_valid = 1; br_taken = 1; br_reg = 0; br_pc = 64'h1008;
    ExtImm = 64'hFFFF_FFFF_FFFF_FFB5; RegTarget = 64'hDEAD0; inst_ready = 1'b1;
    tick();
    br_valid = 0; inst_ready = 1'b0;
    check("pcrel_kill", {63'd0, inst_valid}, 64'd0);
    check("pcrel_addr", imem_addr, 64'h0EDC);
    wait_valid("pcrel_valid");
    check("pcrel_pc",   inst_pc, 64'h0EDC);
    check("pcrel_inst", {32'd0, inst}, 64'hA500_0EDC);

    // Not-taken report: normal accept, sequential next fetch.
    push_inst(32'hA500_0EDC, 64'h0EDC);
    exp_addr.push_back(64'h0EE0);
    br_valid = 1; br_taken = 0; br_reg = 1; RegTarget = 64'h5000; inst_ready = 1'b1;
    tick();
    br_valid = 0; inst_ready = 1'b0;
    wait_valid("nt_valid");
    check("nt_pc", inst_pc, 64'h0EE0);

    // Register branch from HOLD.
    exp_addr.push_back(64'h2000);
    br_valid = 1; br_taken = 1; br_reg = 1; RegTarget = 64'h2000;
    br_pc = 64'h1234; ExtImm = 64'h100;
    tick();
    br_valid = 0;
    check("reg_kill", {63'd0, inst_valid}, 64'd0);
    check("reg_addr", imem_addr, 64'h2000);
    wait_valid("reg_valid");
    check("reg_pc",   inst_pc, 64'h2000);
    check("reg_inst", {32'd0, inst}, 64'hA500_2000);

    // Redirect while a 3-wait fetch is outstanding.
    wait_cycles = 3;
    push_inst(32'hA500_2000, 64'h2000);
    exp_addr.push_back(64'h2004);
    exp_addr.push_back(64'h3000);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    br_valid = 1; br_taken = 1; br_reg = 1; RegTarget = 64'h3000;
    tick();
    br_valid = 0;
    check("ws_hold1", imem_addr, 64'h2004);
    check("ws_req",   {63'd0, imem_req}, 64'd1);
    tick();
    check("ws_hold2", imem_addr, 64'h2004);
    wait_valid("ws_valid");
    check("ws_pc",   inst_pc, 64'h3000);
    check("ws_inst", {32'd0, inst}, 64'hA500_3000);

    // Async reset in the middle of an outstanding fetch.
    push_inst(32'hA500_3000, 64'h3000);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    tick();
    #2 resetl = 1'b0;
    #1;
    check("ar_req",   {63'd0, imem_req},   64'd0);
    check("ar_addr",  imem_addr,           64'd0);
    check("ar_valid", {63'd0, inst_valid}, 64'd0);
    check("ar_inst",  {32'd0, inst},       64'd0);
    check("ar_pc",    inst_pc,             64'd0);

    // PC wrap from the top of the address space.
    StartPC = 64'hFFFF_FFFF_FFFF_FFFC;
    wait_cycles = 0;
    repeat (2) @(posedge CLK);
    #1;
    exp_addr.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_addr.push_back(64'h0);
    push_inst(32'hA5FF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
    inst_ready = 1'b1;
    resetl = 1'b1;
    wait_inst_drain("wrap_stream");
    inst_ready = 1'b0;
    wait_valid("wrap_valid");
    check("wrap_pc",   inst_pc, 64'h0);
    check("wrap_inst", {32'd0, inst}, 64'hA500_0000);

    repeat (3) tick();
    check("addr_q_empty", 64'(exp_addr.size()), 64'd0);
    check("inst_q_empty", 64'(exp_inst.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
